// File: rtl/usbfs_uart_pkg.sv
// rtl/usbfs_uart_pkg.sv - shared types and helpers for the USB FS debug UART transmitter
package usbfs_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    function automatic int frame_bits(input int dw, input int stop, input int par);
        return 1 + dw + par + stop;
    endfunction

endpackage

// File: rtl/usbfs_sync_fifo.sv
// rtl/usbfs_sync_fifo.sv - synchronous FIFO with wrap-bit pointers and registered read port
module usbfs_sync_fifo #(
    parameter int DW    = 8,
    parameter int ASIZE = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en_i,
    input  logic [DW-1:0]    wr_data_i,
    input  logic             rd_en_i,
    output logic [DW-1:0]    rd_data_o,
    output logic             full_o,
    output logic             empty_q_o,
    output logic [ASIZE:0]   level_o
);

    logic [DW-1:0]  mem_q [2**ASIZE];
    logic [DW-1:0]  rd_data_q;
    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           empty_q;
    logic           full, empty, wr_fire, rd_fire;

    assign full    = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                     (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign wr_fire = wr_en_i && !full;
    assign rd_fire = rd_en_i && !empty;
    assign wptr_d  = wr_fire ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d  = rd_fire ? rptr_q + 1'b1 : rptr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            empty_q <= empty;
        end
    end

    // Storage and read register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wr_data_i;
        end
        rd_data_q <= mem_q[rptr_q[ASIZE-1:0]];
    end

    assign rd_data_o = rd_data_q;
    assign full_o    = full;
    assign empty_q_o = empty_q;
    assign level_o   = wptr_q - rptr_q;

endmodule

// File: rtl/usbfs_debug_uart_tx_ext.sv
// rtl/usbfs_debug_uart_tx_ext.sv - FIFO-buffered debug UART transmitter; USBFS_UART_TX_PARITY_EN adds a parity bit
module usbfs_debug_uart_tx_ext
    import usbfs_uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int ASIZE      = 10,
    parameter int DW         = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DW-1:0]    tx_data,
    input  logic             tx_en,
    output logic             tx_rdy,
    output logic [ASIZE:0]   fifo_level,
    output logic             tx_busy,
    output logic             o_uart_tx
);

`ifdef USBFS_UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME_BITS = frame_bits(DW, STOP_BITS, PAR_EN);

    if (CLK_DIV < 2 || ASIZE < 1 || DW < 5 || DW > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || FRAME_BITS > 15) begin : g_bad_params
        $error("usbfs_debug_uart_tx_ext: parameter out of range");
    end

    uart_tx_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  shift_q, shift_d;
    logic [3:0]     idx_q, idx_d;
    logic           line_q, line_d;
    logic           busy_q;
    logic           tick, pop, load;
    logic           full, empty_q;
    logic [DW-1:0]  rd_data;
`ifdef USBFS_UART_TX_PARITY_EN
    logic           par_q, par_d;
`endif

    usbfs_sync_fifo #(
        .DW    (DW),
        .ASIZE (ASIZE)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (tx_en),
        .wr_data_i (tx_data),
        .rd_en_i   (pop),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_q_o (empty_q),
        .level_o   (fifo_level)
    );

    assign tick  = (cnt_q == CW'(CLK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        line_d  = line_q;
        load    = 1'b0;
`ifdef USBFS_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (tick) begin
            unique case (state_q)
                IDLE: load = !empty_q;
                START, DATA: begin
                    if (state_q == DATA && idx_q == 4'(DW)) begin
`ifdef USBFS_UART_TX_PARITY_EN
                        state_d = PARITY;
                        line_d  = par_q;
`else
                        state_d = STOP;
                        line_d  = 1'b1;
                        idx_d   = 4'd1;
`endif
                    end else begin
                        // idx counts data bits already placed on the line
                        state_d = DATA;
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = (state_q == START) ? 4'd1 : idx_q + 4'd1;
`ifdef USBFS_UART_TX_PARITY_EN
                        par_d   = par_q ^ shift_q[0];
`endif
                    end
                end
`ifdef USBFS_UART_TX_PARITY_EN
                PARITY: begin
                    state_d = STOP;
                    line_d  = 1'b1;
                    idx_d   = 4'd1;
                end
`endif
                STOP: begin
                    if (idx_q == 4'(STOP_BITS)) begin
                        load    = !empty_q;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    line_d  = 1'b1;
                end
            endcase
            if (load) begin
                state_d = START;
                line_d  = 1'b0;
                shift_d = rd_data;
`ifdef USBFS_UART_TX_PARITY_EN
                par_d   = (PARITY_ODD != 0);
`endif
            end
        end
    end

    assign pop = load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef USBFS_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            busy_q  <= (state_d != IDLE);
`ifdef USBFS_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_rdy    = !full;
    assign tx_busy   = busy_q;
    assign o_uart_tx = line_q;

endmodule

// File: tb/tb_usbfs_debug_uart_tx_ext.sv
// tb/tb_usbfs_debug_uart_tx_ext.sv - self-checking bench for usbfs_debug_uart_tx_ext
module tb_usbfs_debug_uart_tx_ext;

    localparam int CLK_DIV    = 4;
    localparam int ASIZE      = 2;
    localparam int DW         = 8;
    localparam int STOP_BITS  = 2;
    localparam int PARITY_ODD = 0;
`ifdef USBFS_UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int FBITS  = 1 + DW + PAR_EN + STOP_BITS;
    localparam int FCYC   = FBITS * CLK_DIV;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [DW-1:0]  tx_data = '0;
    logic           tx_en = 1'b0;
    logic           tx_rdy;
    logic [ASIZE:0] fifo_level;
    logic           tx_busy;
    logic           o_uart_tx;

    int vectors = 0;
    int miscompares = 0;

    usbfs_debug_uart_tx_ext #(
        .CLK_DIV    (CLK_DIV),
        .ASIZE      (ASIZE),
        .DW         (DW),
        .STOP_BITS  (STOP_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .tx_rdy     (tx_rdy),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .o_uart_tx  (o_uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of bit period k of a frame carrying w: start, data LSB first, parity, stops.
    function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= DW) return w[k-1];
        if (PAR_EN == 1 && k == DW + 1) return 1'(($countones(w) + PARITY_ODD) % 2);
        return 1'b1;
    endfunction

    task automatic wait_start();
        int g = 0;
        while (o_uart_tx !== 1'b0 && g < 3 * CLK_DIV) begin
            chk("idle_busy", 32'(tx_busy), 32'd0);
            @(negedge clk);
            g++;
        end
        chk("start_seen", 32'(o_uart_tx), 32'd0);
    endtask

    // Checks one frame from start-bit cycle 'skip' to the end, then the first cycle after it.
    task automatic check_frame(input logic [DW-1:0] w, input int skip, input bit more);
        wait_start();
        for (int c = skip; c < FCYC; c++) begin
            chk($sformatf("bit%0d_w%02h", c / CLK_DIV, w), 32'(o_uart_tx), 32'(exp_bit(w, c / CLK_DIV)));
            chk("busy_in_frame", 32'(tx_busy), 32'd1);
            @(negedge clk);
        end
        chk("after_line", 32'(o_uart_tx), more ? 32'd0 : 32'd1);
        chk("after_busy", 32'(tx_busy), more ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] w, w0, d_drop, d_keep;
        int n;
        bit first;

        repeat (3) @(negedge clk);
        chk("rst_line", 32'(o_uart_tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_rdy", 32'(tx_rdy), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single fixed word.
        tx_data = 8'h55; tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        check_frame(8'h55, 0, 1'b0);
        chk("t1_level", 32'(fifo_level), 32'd0);

        // Fill while the line is busy, then write across the pop edge.
        w0 = DW'($urandom); tx_data = w0; tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        wait_start();
        for (int i = 0; i < 5; i++) begin
            w = DW'($urandom);
            tx_data = w; tx_en = 1'b1;
            if (i < 4) q.push_back(w);
            @(negedge clk);
        end
        tx_en = 1'b0;
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_rdy", 32'(tx_rdy), 32'd0);
        for (int c = 5; c < FCYC - 1; c++) begin
            chk($sformatf("w0_bit%0d", c / CLK_DIV), 32'(o_uart_tx), 32'(exp_bit(w0, c / CLK_DIV)));
            @(negedge clk);
        end
        chk("w0_last", 32'(o_uart_tx), 32'd1);
        chk("pre_pop_level", 32'(fifo_level), 32'd4);
        d_drop = DW'($urandom); tx_data = d_drop; tx_en = 1'b1;
        @(negedge clk);
        chk("pop_level", 32'(fifo_level), 32'd3);
        chk("pop_rdy", 32'(tx_rdy), 32'd1);
        d_keep = DW'($urandom); tx_data = d_keep;
        @(negedge clk);
        tx_en = 1'b0;
        chk("refill_level", 32'(fifo_level), 32'd4);
        q.push_back(d_keep);
        first = 1'b1;
        while (q.size() > 0) begin
            w = q.pop_front();
            check_frame(w, first ? 1 : 0, q.size() > 0);
            first = 1'b0;
        end
        chk("drain_level", 32'(fifo_level), 32'd0);

        // Reset in the middle of a frame with words queued.
        tx_data = 8'hFF; tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        wait_start();
        for (int i = 0; i < 3; i++) begin
            tx_data = DW'($urandom); tx_en = 1'b1;
            @(negedge clk);
        end
        tx_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", 32'(tx_busy), 32'd1);
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        rstn = 1'b0;
        #1;
        chk("rst_mid_line", 32'(o_uart_tx), 32'd1);
        chk("rst_mid_busy", 32'(tx_busy), 32'd0);
        chk("rst_mid_level", 32'(fifo_level), 32'd0);
        chk("rst_mid_rdy", 32'(tx_rdy), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            chk("post_rst_line", 32'(o_uart_tx), 32'd1);
            chk("post_rst_busy", 32'(tx_busy), 32'd0);
        end

        // Random bursts of 1..3 words, sent back-to-back.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                w = DW'($urandom);
                tx_data = w; tx_en = 1'b1;
                q.push_back(w);
                @(negedge clk);
            end
            tx_en = 1'b0;
            while (q.size() > 0) begin
                w = q.pop_front();
                check_frame(w, 0, q.size() > 0);
            end
            chk("burst_level", 32'(fifo_level), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
